// File: rtl/sprite_blitter.sv
// CHIP-8 DXYN sprite blitter: XORs an N-row, 8-pixel-wide sprite into a 64x32 monochrome framebuffer.
// Latency 5N+1 cycles (byte-aligned X) or 8N+1 cycles (unaligned X); memory reads stall until acked.
module sprite_blitter #(
  parameter logic [11:0] FB_BASE = 12'hF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] sprite_addr,
  input  logic [7:0]  x_in,
  input  logic [7:0]  y_in,
  input  logic [3:0]  n_rows,
  output logic        busy,
  output logic        done,
  output logic        collision,
  output logic        mem_read,
  output logic [11:0] mem_read_addr,
  input  logic [7:0]  mem_read_data,
  input  logic        mem_read_ack,
  output logic        mem_write,
  output logic [11:0] mem_write_addr,
  output logic [7:0]  mem_write_data
);

  typedef enum logic [3:0] {
    IDLE,
    RD_SPR,
    WT_SPR,
    RD_FB0,
    WT_FB0,
    WR_FB0,
    RD_FB1,
    WT_FB1,
    WR_FB1,
    DONE
  } state_t;

  state_t      state;
  logic [11:0] spr_base;
  logic [5:0]  xr;
  logic [4:0]  yr;
  logic [3:0]  nr;
  logic [3:0]  r;
  logic [7:0]  spr;

  logic [4:0]  row;
  logic [2:0]  shift;
  logic [2:0]  c0;
  logic [2:0]  c1;
  logic [3:0]  inv_shift;
  logic [7:0]  m0;
  logic [7:0]  m1;
  logic [11:0] fb_addr0;
  logic [11:0] fb_addr1;
  logic [3:0]  r_next;
  logic        last_row;
  logic [11:0] next_spr_addr;
  logic        unused_coord_bits;

  assign unused_coord_bits = ^{x_in[7:6], y_in[7:5]};

  // 5-bit row and 3-bit column arithmetic give the vertical and horizontal wrap for free.
  always_comb begin
    row           = yr + {1'b0, r};
    shift         = xr[2:0];
    c0            = xr[5:3];
    c1            = c0 + 3'd1;
    inv_shift     = 4'd8 - {1'b0, shift};
    m0            = spr >> shift;
    m1            = spr << inv_shift;
    fb_addr0      = FB_BASE + {4'd0, row, c0};
    fb_addr1      = FB_BASE + {4'd0, row, c1};
    r_next        = r + 4'd1;
    last_row      = (r_next >= nr);
    next_spr_addr = spr_base + {8'd0, r_next};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      collision      <= 1'b0;
      mem_read       <= 1'b0;
      mem_read_addr  <= 12'd0;
      mem_write      <= 1'b0;
      mem_write_addr <= 12'd0;
      mem_write_data <= 8'd0;
      spr_base       <= 12'd0;
      xr             <= 6'd0;
      yr             <= 5'd0;
      nr             <= 4'd0;
      r              <= 4'd0;
      spr            <= 8'd0;
    end else begin
      // Strobes and done are single-cycle pulses; states below raise them for one cycle.
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      done      <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            spr_base  <= sprite_addr;
            xr        <= x_in[5:0];
            yr        <= y_in[4:0];
            nr        <= n_rows;
            r         <= 4'd0;
            collision <= 1'b0;
            if (n_rows == 4'd0) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state         <= RD_SPR;
              busy          <= 1'b1;
              mem_read      <= 1'b1;
              mem_read_addr <= sprite_addr;
            end
          end
        end

        RD_SPR: state <= WT_SPR;

        WT_SPR: begin
          if (mem_read_ack) begin
            spr           <= mem_read_data;
            state         <= RD_FB0;
            mem_read      <= 1'b1;
            mem_read_addr <= fb_addr0;
          end
        end

        RD_FB0: state <= WT_FB0;

        WT_FB0: begin
          if (mem_read_ack) begin
            state          <= WR_FB0;
            mem_write      <= 1'b1;
            mem_write_addr <= fb_addr0;
            mem_write_data <= mem_read_data ^ m0;
            collision      <= collision | (|(mem_read_data & m0));
          end
        end

        WR_FB0: begin
          if (shift != 3'd0) begin
            state         <= RD_FB1;
            mem_read      <= 1'b1;
            mem_read_addr <= fb_addr1;
          end else begin
            r <= r_next;
            if (last_row) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state         <= RD_SPR;
              mem_read      <= 1'b1;
              mem_read_addr <= next_spr_addr;
            end
          end
        end

        RD_FB1: state <= WT_FB1;

        WT_FB1: begin
          if (mem_read_ack) begin
            state          <= WR_FB1;
            mem_write      <= 1'b1;
            mem_write_addr <= fb_addr1;
            mem_write_data <= mem_read_data ^ m1;
            collision      <= collision | (|(mem_read_data & m1));
          end
        end

        WR_FB1: begin
          r <= r_next;
          if (last_row) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state         <= RD_SPR;
            mem_read      <= 1'b1;
            mem_read_addr <= next_spr_addr;
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: behavioural memory with one-cycle ack, scoreboard of expected writes and done pulses.
module tb_sprite_blitter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] sprite_addr;
  logic [7:0]  x_in;
  logic [7:0]  y_in;
  logic [3:0]  n_rows;
  logic        busy;
  logic        done;
  logic        collision;
  logic        mem_read;
  logic [11:0] mem_read_addr;
  logic [7:0]  mem_read_data = 8'd0;
  logic        mem_read_ack = 1'b0;
  logic        mem_write;
  logic [11:0] mem_write_addr;
  logic [7:0]  mem_write_data;

  always #5 clk = ~clk;

  sprite_blitter #(.FB_BASE(12'hF00)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .sprite_addr    (sprite_addr),
    .x_in           (x_in),
    .y_in           (y_in),
    .n_rows         (n_rows),
    .busy           (busy),
    .done           (done),
    .collision      (collision),
    .mem_read       (mem_read),
    .mem_read_addr  (mem_read_addr),
    .mem_read_data  (mem_read_data),
    .mem_read_ack   (mem_read_ack),
    .mem_write      (mem_write),
    .mem_write_addr (mem_write_addr),
    .mem_write_data (mem_write_data)
  );

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    int   cycle;
    logic coll;
  } dn_t;

  wr_t wq[$];
  dn_t dq[$];

  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   t0       = 0;
  int   req_cnt  = 0;
  int   req_seen = 0;
  int   req_kind = 0;
  logic no_read  = 1'b0;

  logic        ld_en  = 1'b0;
  logic [11:0] ld_addr = 12'd0;
  logic [7:0]  ld_dat  = 8'd0;
  logic        clr_fb = 1'b0;
  logic [7:0]  mem [0:4095];

  // Memory model: ack exactly one cycle after the strobe, writes land at the clock edge.
  always @(posedge clk) begin
    cyc          <= cyc + 1;
    mem_read_ack <= mem_read;
    if (mem_read) mem_read_data <= mem[mem_read_addr];
    if (mem_write) mem[mem_write_addr] <= mem_write_data;
    if (ld_en) mem[ld_addr] <= ld_dat;
    if (clr_fb) for (int i = 0; i < 256; i++) mem[12'hF00 + i] <= 8'd0;
  end

  // Monitor: owns all check/error counting.
  always @(negedge clk) begin : monitor
    wr_t ew;
    dn_t ed;
    if (mem_write) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", mem_write_addr, mem_write_data);
      end else begin
        ew = wq.pop_front();
        if (mem_write_addr !== ew.addr || mem_write_data !== ew.data) begin
          errors++;
          $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                   mem_write_addr, mem_write_data, ew.addr, ew.data);
        end
      end
    end
    if (mem_read || mem_write) begin
      checks++;
      if (mem_read && mem_write) begin
        errors++;
        $display("FAIL strobe_overlap: got mem_read=1 mem_write=1, expected at most one");
      end else if (no_read && mem_read) begin
        errors++;
        $display("FAIL no_read: got mem_read=1 addr=%h, expected no read", mem_read_addr);
      end
    end
    if (done) begin
      checks++;
      if (dq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc - t0);
      end else begin
        ed = dq.pop_front();
        if ((cyc - t0) != ed.cycle || collision !== ed.coll || busy !== 1'b0) begin
          errors++;
          $display("FAIL done: got cycle=%0d collision=%b busy=%b, expected cycle=%0d collision=%b busy=0",
                   cyc - t0, collision, busy, ed.cycle, ed.coll);
        end
      end
    end
    if (req_cnt != req_seen) begin
      req_seen = req_cnt;
      checks++;
      case (req_kind)
        1: if ({busy, done, collision, mem_read, mem_write, mem_read_addr, mem_write_addr, mem_write_data} !== 37'd0) begin
             errors++;
             $display("FAIL reset_state: got busy=%b done=%b coll=%b rd=%b wr=%b raddr=%h waddr=%h wdata=%h, expected all 0",
                      busy, done, collision, mem_read, mem_write, mem_read_addr, mem_write_addr, mem_write_data);
           end
        2: begin
             errors++;
             $display("FAIL done_timeout: got no done within bound, expected done");
           end
        default: if (wq.size() != 0 || dq.size() != 0) begin
             errors++;
             $display("FAIL leftover: got %0d writes %0d dones pending, expected 0 0", wq.size(), dq.size());
           end
      endcase
    end
  end

  task automatic request(input int k);
    req_kind = k;
    req_cnt++;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic load(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_dat = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic clear_fb();
    @(negedge clk);
    clr_fb = 1'b1;
    @(negedge clk);
    clr_fb = 1'b0;
  endtask

  task automatic exp_wr(input logic [11:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    wq.push_back(w);
  endtask

  task automatic exp_done(input int c, input logic coll);
    dn_t e;
    e.cycle = c; e.coll = coll;
    dq.push_back(e);
  endtask

  task automatic draw(input logic [11:0] sa, input logic [7:0] x, input logic [7:0] y, input logic [3:0] n);
    @(negedge clk);
    sprite_addr = sa; x_in = x; y_in = y; n_rows = n;
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!done) request(2);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    sprite_addr = 12'd0; x_in = 8'd0; y_in = 8'd0; n_rows = 4'd0;
    repeat (3) @(negedge clk);
    request(1);
    reset = 1'b0;

    // Aligned single row, then redraw erases and collides.
    clear_fb();
    load(12'h050, 8'hF0);
    exp_wr(12'hF00, 8'hF0); exp_done(6, 1'b0);
    draw(12'h050, 8'd0, 8'd0, 4'd1); wait_done();
    exp_wr(12'hF00, 8'h00); exp_done(6, 1'b1);
    draw(12'h050, 8'd0, 8'd0, 4'd1); wait_done();

    // Zero rows: no memory traffic, collision cleared.
    no_read = 1'b1;
    exp_done(1, 1'b0);
    draw(12'h050, 8'd0, 8'd0, 4'd0); wait_done();
    no_read = 1'b0;

    // Unaligned: split across two bytes, then redraw collides.
    clear_fb();
    load(12'h060, 8'hFF);
    exp_wr(12'hF00, 8'h1F); exp_wr(12'hF01, 8'hE0); exp_done(9, 1'b0);
    draw(12'h060, 8'd3, 8'd0, 4'd1); wait_done();
    exp_wr(12'hF00, 8'h00); exp_wr(12'hF01, 8'h00); exp_done(9, 1'b1);
    draw(12'h060, 8'd3, 8'd0, 4'd1); wait_done();

    // Corner wrap in both axes.
    clear_fb();
    load(12'h070, 8'hC3); load(12'h071, 8'hC3);
    exp_wr(12'hFFF, 8'h03); exp_wr(12'hFF8, 8'h0C);
    exp_wr(12'hF07, 8'h03); exp_wr(12'hF00, 8'h0C); exp_done(17, 1'b0);
    draw(12'h070, 8'd62, 8'd31, 4'd2); wait_done();

    // Sprite address wraps 0xFFF -> 0x000; unused coordinate bits ignored.
    clear_fb();
    load(12'hFFF, 8'h81); load(12'h000, 8'h80);
    exp_wr(12'hF08, 8'h08); exp_wr(12'hF09, 8'h10);
    exp_wr(12'hF10, 8'h08); exp_wr(12'hF11, 8'h00); exp_done(17, 1'b0);
    draw(12'hFFF, 8'hC4, 8'hE1, 4'd2); wait_done();

    // Reset during row 1 WT_FB0: row 0 write stays, no done, then a normal draw.
    clear_fb();
    load(12'h050, 8'hF0); load(12'h051, 8'hAA);
    exp_wr(12'hF00, 8'hF0);
    draw(12'h050, 8'd0, 8'd0, 4'd2);
    for (int k = 0; k < 50 && (cyc - t0) < 9; k++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    request(1);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    exp_wr(12'hF00, 8'h00); exp_done(6, 1'b1);
    draw(12'h050, 8'd0, 8'd0, 4'd1); wait_done();

    repeat (3) @(negedge clk);
    request(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
